// File: rtl/max_pkg.sv
// max_pkg: shared types and constants for max_stream_reducer.
//   state_e   - frame FSM encoding (IDLE, ACC, HOLD)
//   SLICE_W   - width of one compare slice in the magnitude cascade
//   idx_width - index width for a given maximum frame length
package max_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no frame open
    ACC  = 2'd1,  // frame open, accumulating
    HOLD = 2'd2   // result registered, waiting for the consumer
  } state_e;

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/max_cmp_slice.sv
// max_cmp_slice: one 4-bit unsigned magnitude-compare stage.
// Stages chain from the least-significant nibble upward, so a decision made
// in a higher nibble overrides whatever the lower nibbles concluded.
//   a, b    - nibble of candidate (a) and running maximum (b)
//   gt_in   - lower nibbles say a > b
//   eq_in   - lower nibbles are all equal
//   gt_out  - a > b over this and all lower nibbles
//   eq_out  - equal over this and all lower nibbles
module max_cmp_slice
  import max_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               gt_in,
  input  logic               eq_in,
  output logic               gt_out,
  output logic               eq_out
);

  logic nib_eq;

  assign nib_eq = (a == b);
  assign gt_out = (a > b) | (nib_eq & gt_in);
  assign eq_out = nib_eq & eq_in;

endmodule

// File: rtl/max_stream_reducer.sv
// max_stream_reducer: reduces each frame of a valid/ready sample stream to
// its maximum, the index of the first occurrence of that maximum, and the
// sample count. A frame closes on in_last or when it reaches N_MAX samples.
//
// Handshakes: a beat transfers on a rising edge where valid and ready are
// both high; the producer holds data/last stable while valid is high and
// ready is low, and the block holds out_* stable while out_valid is high and
// out_ready is low.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   in_valid   - sample present
//   in_ready   - block can accept a sample (low in HOLD and during reset)
//   in_data    - W-bit unsigned sample
//   in_last    - final sample of the frame
//   out_valid  - frame result held
//   out_ready  - consumer accepts the result
//   out_max    - frame maximum
//   out_idx    - zero-based index of the first occurrence of out_max
//   out_count  - samples in the frame (1..N_MAX)
//   out_trunc  - frame was closed by the N_MAX limit without in_last
//   dbg_state  - current FSM state, for observation only
module max_stream_reducer
  import max_pkg::*;
#(
  parameter  int W     = 16,
  parameter  int N_MAX = 256,
  localparam int IW    = idx_width(N_MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_max,
  output logic [IW-1:0] out_idx,
  output logic [IW:0]   out_count,
  output logic          out_trunc,
  output state_e        dbg_state
);

  localparam int         NS      = W / SLICE_W;
  localparam logic [IW:0] N_MAX_C = (IW+1)'(N_MAX);
  localparam logic [IW:0] ONE_C   = (IW+1)'(1);

  state_e        state_q, state_d;
  logic [W-1:0]  run_max_q, run_max_d;
  logic [IW-1:0] run_idx_q, run_idx_d;
  logic [IW:0]   cnt_q, cnt_d;
  logic [W-1:0]  out_max_q, out_max_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic [IW:0]   out_count_q, out_count_d;
  logic          out_trunc_q, out_trunc_d;

  logic          accept;
  logic          cand_gt;
  logic          cand_eq;
  logic          update;
  logic          close;
  logic          trunc;
  logic [IW:0]   cnt_inc;

  // ---------------------------------------------------------------------------
  // Candidate vs running maximum: nibble cascade, LSB nibble first.
  // ---------------------------------------------------------------------------
  logic [NS:0] gt_c;
  logic [NS:0] eq_c;

  assign gt_c[0] = 1'b0;
  assign eq_c[0] = 1'b1;

  for (genvar s = 0; s < NS; s++) begin : g_slice
    max_cmp_slice u_slice (
      .a      (in_data[s*SLICE_W +: SLICE_W]),
      .b      (run_max_q[s*SLICE_W +: SLICE_W]),
      .gt_in  (gt_c[s]),
      .eq_in  (eq_c[s]),
      .gt_out (gt_c[s+1]),
      .eq_out (eq_c[s+1])
    );
  end

  assign cand_gt = gt_c[NS];
  assign cand_eq = eq_c[NS];
  // Ties keep the earlier index, so only a strict win updates.
  assign update  = cand_gt & ~cand_eq;

  // ---------------------------------------------------------------------------
  // Handshake decode. Ready is a pure state decode, forced low while the
  // block is held in reset so nothing is taken before the state is known.
  // ---------------------------------------------------------------------------
  assign in_ready = ~rst & (state_q != HOLD);
  assign accept   = in_valid & in_ready;
  assign cnt_inc  = cnt_q + ONE_C;

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    run_max_d   = run_max_q;
    run_idx_d   = run_idx_q;
    cnt_d       = cnt_q;
    out_max_d   = out_max_q;
    out_idx_d   = out_idx_q;
    out_count_d = out_count_q;
    out_trunc_d = out_trunc_q;
    close       = 1'b0;
    trunc       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          // First sample reloads the running registers; nothing from the
          // previous frame survives past this point.
          run_max_d = in_data;
          run_idx_d = '0;
          cnt_d     = ONE_C;
          if (in_last) begin
            close = 1'b1;
          end else begin
            state_d = ACC;
          end
        end
      end

      ACC: begin
        if (accept) begin
          if (update) begin
            run_max_d = in_data;
            // cnt_q is at most N_MAX-1 here, so it fits in an index.
            run_idx_d = cnt_q[IW-1:0];
          end
          cnt_d = cnt_inc;
          if (in_last || (cnt_inc == N_MAX_C)) begin
            close = 1'b1;
            trunc = ~in_last;
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (close) begin
      out_max_d   = run_max_d;
      out_idx_d   = run_idx_d;
      out_count_d = cnt_d;
      out_trunc_d = trunc;
      state_d     = HOLD;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      run_max_q   <= '0;
      run_idx_q   <= '0;
      cnt_q       <= '0;
      out_max_q   <= '0;
      out_idx_q   <= '0;
      out_count_q <= '0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_max_q   <= run_max_d;
      run_idx_q   <= run_idx_d;
      cnt_q       <= cnt_d;
      out_max_q   <= out_max_d;
      out_idx_q   <= out_idx_d;
      out_count_q <= out_count_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign out_max   = out_max_q;
  assign out_idx   = out_idx_q;
  assign out_count = out_count_q;
  assign out_trunc = out_trunc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_max_stream_reducer.sv
module tb_max_stream_reducer;
  import max_pkg::*;

  localparam int W     = 16;
  localparam int N_MAX = 256;
  localparam int IW    = 8;
  localparam int RW    = W + IW + IW + 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_max;
  logic [IW-1:0] out_idx;
  logic [IW:0]   out_count;
  logic          out_trunc;
  state_e        dbg_state;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 1;  // 0: out_ready low, 1: high, 2: random

  logic [RW-1:0] exp_q[$];   // expected frame results, oldest first
  logic [W-1:0]  cur_q[$];   // samples of the frame currently being issued

  max_stream_reducer #(.W(W), .N_MAX(N_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_idx   (out_idx),
    .out_count (out_count),
    .out_trunc (out_trunc),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Frame result from the sample list: max over all samples, first position
  // holding it, number of samples.
  task automatic close_frame(input logic tr);
    logic [W-1:0] mx;
    int           ix;
    int           n;
    n  = cur_q.size();
    mx = '0;
    foreach (cur_q[i]) if (cur_q[i] > mx) mx = cur_q[i];
    ix = -1;
    foreach (cur_q[i]) if (ix < 0 && cur_q[i] == mx) ix = i;
    exp_q.push_back({mx, IW'(ix), (IW+1)'(n), tr});
    cur_q.delete();
  endtask

  task automatic model_push(input logic [W-1:0] d, input logic last);
    cur_q.push_back(d);
    if (last) close_frame(1'b0);
    else if (cur_q.size() == N_MAX) close_frame(1'b1);
  endtask

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [W-1:0] d, input logic last);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    guard    = 0;
    while (!in_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: actual=0 required=1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_push(d, last);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // out_ready changes just after the active edge
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  // Every cycle a result is held it must equal the oldest expected result;
  // it is retired when the handshake is about to happen.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: actual max=%0h idx=%0d cnt=%0d required none",
                 out_max, out_idx, out_count);
      end else begin
        chk("result", 64'({out_max, out_idx, out_count, out_trunc}), 64'(exp_q[0]));
        chk("ready_in_hold", 64'(in_ready), 64'd0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;

    // reset values
    @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_max",   64'(out_max),   64'd0);
    chk("rst_out_idx",   64'(out_idx),   64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_trunc", 64'(out_trunc), 64'd0);
    chk("rst_state",     64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // basic frame, latency check
    rdy_mode = 1;
    send_beat(16'd3, 1'b0);
    send_beat(16'd9, 1'b0);
    send_beat(16'd7, 1'b1);
    #1;
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    chk("basic_max", 64'(out_max), 64'd9);
    chk("basic_idx", 64'(out_idx), 64'd1);
    idle_cycle();
    wait_drain(50);

    // ties keep the first index
    send_beat(16'd5, 1'b0);
    send_beat(16'd12, 1'b0);
    send_beat(16'd12, 1'b0);
    send_beat(16'd4, 1'b1);
    idle_cycle();
    wait_drain(50);

    // nibble cascade
    send_beat(16'h0F00, 1'b0);
    send_beat(16'h00FF, 1'b0);
    send_beat(16'h0F01, 1'b1);
    idle_cycle();
    wait_drain(50);

    // 300 samples, value = index: truncated frame then 44-sample frame
    for (int i = 0; i < 300; i++) send_beat(W'(i), (i == 299));
    idle_cycle();
    wait_drain(50);

    // single-sample frame held while the consumer stalls
    rdy_mode = 0;
    @(posedge clk);
    #1;
    send_beat(16'hFFFF, 1'b1);
    idle_cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready",  64'(in_ready),  64'd0);
      chk("stall_out_max",   64'(out_max),   64'hFFFF);
    end
    rdy_mode = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("post_hs_in_ready",  64'(in_ready),  64'd1);
    chk("post_hs_out_valid", 64'(out_valid), 64'd0);
    wait_drain(10);

    // reset mid-frame discards the partial frame
    send_beat(16'd40, 1'b0);
    send_beat(16'd50, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    cur_q.delete();
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_max",   64'(out_max),   64'd0);
    chk("midrst_out_count", 64'(out_count), 64'd0);
    chk("midrst_state",     64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    send_beat(16'd1, 1'b0);
    send_beat(16'd2, 1'b1);
    idle_cycle();
    wait_drain(50);

    // randomized frames with random gaps and random consumer stalls
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      int len;
      bit narrow;
      len    = $urandom_range(1, 20);
      narrow = 1'($urandom_range(0, 1));
      for (int b = 0; b < len; b++) begin
        logic [W-1:0] v;
        v = narrow ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 65535));
        if ($urandom_range(0, 3) == 0) idle_cycle();
        send_beat(v, (b == len - 1));
      end
    end
    idle_cycle();

    rdy_mode = 1;
    wait_drain(200);
    chk("no_open_frame", 64'(cur_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: actual=running required=finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
